mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single 16-bit external memory port between two cache-side requesters: port 0 is the instruction cache and port 1 is the data cache.
- Read requests are 4-word line refills at a fixed memory latency.
- Write requests are single-word write-throughs.
- Sits between the caches and the memory.
- Owns all memory-side sequencing (address stepping, wait counting), so the caches only issue a request and then consume the returned words.

Parameters:
- MEM_LAT, 4: cycles the memory address must be held before mem_rdata is valid; legal range 1..15.
- BURST_LEN, 4: words per read refill; fixed at 4 (line = 4 x 16-bit).

Ports:
- clk_100  in  1  system clock; all logic on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- reqN_valid  in  1  (N=0,1) request pending; held high until reqN_done.
- reqN_we  in  1  1 = single-word write, 0 = line read; stable while valid.
- reqN_addr  in  16  word address; reads use [15:2] only; stable while valid.
- reqN_wdata  in  16  write data; stable while valid.
- reqN_grant  out  1  high from the cycle after acceptance through the done cycle inclusive.
- reqN_rdata  out  16  returned read word.
- reqN_rvalid  out  1  one-cycle pulse per returned word.
- reqN_rword  out  2  index of the word in reqN_rdata (equals addr[1:0] of the fetched word).
- reqN_done  out  1  one-cycle pulse; transaction complete.
- mem_addr  out  16  memory address.
- mem_wdata  out  16  memory write data.
- mem_we  out  1  memory write strobe.
- mem_rdata  in  16  memory read data; valid MEM_LAT cycles after mem_addr changes.

Behaviour:
- Reset values:
  - state = IDLE.
  - All grant, rvalid, done outputs and mem_we = 0.
  - mem_addr = 0, mem_wdata = 0, all rdata = 0, all rword = 0.
  - Word counter = 0, wait counter = 0.
  - last_served = 1, so port 0 wins the first tie.
- All outputs are registered.
- States:
  - IDLE: arbitrate.
  - RD: burst read.
  - WR: single write.
  - DONE: one-cycle cool-down.
- IDLE arbitration (cycle T0, decided at the edge ending T0):
  - Only one valid: grant it.
  - Both valid: grant the port != last_served.
  - On grant: latch port, we, addr, wdata; update last_served; assert reqN_grant.
  - Read: mem_addr = {addr[15:2],2'b00}, word = 0, wait = 0, go to RD.
  - Write: mem_addr = addr, mem_wdata = wdata, mem_we = 1, go to WR.
- RD, per word k:
  - mem_addr = {base,k} held for MEM_LAT cycles; wait counts 0..MEM_LAT-1.
  - On the edge where wait == MEM_LAT-1: reqN_rdata <= mem_rdata, reqN_rvalid <= 1, reqN_rword <= k.
  - If k < 3: k++, mem_addr advances, wait = 0.
  - If k = 3: also reqN_done <= 1, go to DONE.
  - Word k is visible in cycle T0+1+(k+1)*MEM_LAT; with MEM_LAT=4, words arrive at T0+5, T0+9, T0+13, T0+17, and done is at T0+17.
- WR:
  - mem_we is high exactly one cycle (T0+1).
  - The edge ending WR clears mem_we, sets reqN_done, and goes to DONE; done is visible at T0+2.
- DONE:
  - Valid inputs are not sampled.
  - The edge ending DONE drops grant, done and rvalid, and goes to IDLE.
  - The requester must drop valid at that same edge.
- rvalid, rdata, rword, grant and done are only ever driven on the granted port; the other port's rvalid, done and grant stay 0.
- A request arriving mid-transaction waits; it is served at the next IDLE.
- Under continuous contention the ports strictly alternate.
- valid dropping mid-transaction is ignored; the burst or write completes and done still pulses.
- rst mid-operation: immediate return to reset values. The partial burst is discarded, no done is issued, mem_we is forced 0.
- mem_we is never high outside WR; mem_addr is stable for all MEM_LAT cycles of each word.

Decomposition:
- Shared package mem_arb_pkg:
  - state encoding constants ST_IDLE, ST_RD, ST_WR, ST_DONE.
  - BURST_LEN = 4.
  - port index constants PORT_ICACHE = 0, PORT_DCACHE = 1.
- One sub-module rr_arbiter_2:
  - combinational winner select from the two valids plus last_served;
  - outputs gnt_any and gnt_idx.
  - The pointer register lives in the parent so that it updates only on an accepted grant.

Test Plan:
- Reset then req0 read at addr 16'h12F7, memory model returns data = addr ^ 16'hA5A5, MEM_LAT=4 -> mem_addr steps 12F4, 12F5, 12F6, 12F7; req0_rvalid at T0+5/9/13/17 with rword 0..3 and matching data; req0_done at T0+17; grant high T0+1..T0+17.
- req1 write addr 16'h00C3, data 16'hBEEF -> mem_we high only in T0+1 with mem_addr 00C3 and mem_wdata BEEF; req1_done at T0+2; no rvalid.
- Both valid in the same cycle after reset, both reads -> port 0 served first, then port 1 served starting at the next IDLE; with both held continuously, grants alternate 0,1,0,1 over 4 transactions.
- req0 read in progress, req1 write asserted at word 1 -> req1 not granted until the IDLE after req0's DONE; req1_grant stays 0 during the burst.
- rst asserted during word 2 of a read -> next cycle: all outputs at reset values, mem_we 0, no done pulse; a following req0 request restarts the burst from word 0.
- MEM_LAT=1 build, single read -> rvalid on 4 consecutive cycles T0+2..T0+5, done at T0+5.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
//   Provides state encoding, bus widths, burst length and port indices.
package mem_arb_pkg;

  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned BURST_LEN = 4;
  localparam int unsigned WORD_W    = 2;
  localparam int unsigned BASE_W    = ADDR_W - WORD_W;
  localparam int unsigned LAT_W     = 4;

  localparam logic PORT_ICACHE = 1'b0;
  localparam logic PORT_DCACHE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } arb_state_e;

  // One cache-side request as presented on a port.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin winner select (purely combinational).
//   req_valid   : pending requests, bit N = port N
//   last_served : port that won the previous accepted grant
//   gnt_any     : at least one request pending
//   gnt_idx     : winning port index
module rr_arbiter_2 (
  input  logic [1:0] req_valid,
  input  logic       last_served,
  output logic       gnt_any,
  output logic       gnt_idx
);

  // A lone requester always wins; on a tie the port not served last wins.
  always_comb begin
    gnt_any = |req_valid;
    if (&req_valid) begin
      gnt_idx = ~last_served;
    end else begin
      gnt_idx = req_valid[1];
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one 16-bit memory port between the I-cache (port 0) and the
// D-cache (port 1). Reads are 4-word line refills with a fixed memory
// latency, writes are single-word write-throughs.
//   clk_100, rst            : clock, synchronous active-high reset
//   reqN_valid/we/addr/wdata: request from port N, held until reqN_done
//   reqN_grant              : port N owns the memory port
//   reqN_rdata/rvalid/rword : returned read word, strobe and word index
//   reqN_done               : one-cycle completion pulse
//   mem_addr/wdata/we       : memory request side
//   mem_rdata               : memory read data, valid MEM_LAT cycles after mem_addr changes
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LAT = 4
) (
  input  logic              clk_100,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_grant,
  output logic [DATA_W-1:0] req0_rdata,
  output logic              req0_rvalid,
  output logic [WORD_W-1:0] req0_rword,
  output logic              req0_done,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_grant,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              req1_rvalid,
  output logic [WORD_W-1:0] req1_rword,
  output logic              req1_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e                   state_q, state_d;
  logic                         port_q, port_d;
  logic                         last_served_q, last_served_d;
  logic [BASE_W-1:0]            base_q, base_d;
  logic [WORD_W-1:0]            word_q, word_d;
  logic [LAT_W-1:0]             wait_q, wait_d;
  logic [1:0]                   grant_q, grant_d;
  logic [1:0]                   rvalid_q, rvalid_d;
  logic [1:0]                   done_q, done_d;
  logic [1:0][DATA_W-1:0]       rdata_q, rdata_d;
  logic [1:0][WORD_W-1:0]       rword_q, rword_d;
  logic [ADDR_W-1:0]            mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]            mem_wdata_q, mem_wdata_d;
  logic                         mem_we_q, mem_we_d;

  logic                         gnt_any;
  logic                         gnt_idx;
  mem_req_t                     sel_req;

  rr_arbiter_2 u_rr (
    .req_valid   ({req1_valid, req0_valid}),
    .last_served (last_served_q),
    .gnt_any     (gnt_any),
    .gnt_idx     (gnt_idx)
  );

  // Request of the arbitration winner.
  always_comb begin
    if (gnt_idx) begin
      sel_req = '{we: req1_we, addr: req1_addr, wdata: req1_wdata};
    end else begin
      sel_req = '{we: req0_we, addr: req0_addr, wdata: req0_wdata};
    end
  end

  // Next-state and output logic; strobes default low every cycle.
  always_comb begin
    state_d       = state_q;
    port_d        = port_q;
    last_served_d = last_served_q;
    base_d        = base_q;
    word_d        = word_q;
    wait_d        = wait_q;
    grant_d       = grant_q;
    rvalid_d      = '0;
    done_d        = '0;
    rdata_d       = rdata_q;
    rword_d       = rword_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_we_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          port_d           = gnt_idx;
          last_served_d    = gnt_idx;
          grant_d          = '0;
          grant_d[gnt_idx] = 1'b1;
          if (sel_req.we) begin
            mem_addr_d  = sel_req.addr;
            mem_wdata_d = sel_req.wdata;
            mem_we_d    = 1'b1;
            state_d     = ST_WR;
          end else begin
            base_d     = sel_req.addr[ADDR_W-1:WORD_W];
            mem_addr_d = {sel_req.addr[ADDR_W-1:WORD_W], WORD_W'(0)};
            word_d     = '0;
            wait_d     = '0;
            state_d    = ST_RD;
          end
        end
      end

      // Each word's address is held for MEM_LAT cycles, then the data is captured.
      ST_RD: begin
        if (wait_q == LAT_W'(MEM_LAT - 1)) begin
          rdata_d[port_q]  = mem_rdata;
          rword_d[port_q]  = word_q;
          rvalid_d[port_q] = 1'b1;
          if (word_q == WORD_W'(BURST_LEN - 1)) begin
            done_d[port_q] = 1'b1;
            state_d        = ST_DONE;
          end else begin
            word_d     = word_q + WORD_W'(1);
            mem_addr_d = {base_q, word_q + WORD_W'(1)};
            wait_d     = '0;
          end
        end else begin
          wait_d = wait_q + LAT_W'(1);
        end
      end

      // mem_we was raised on entry; the default drops it here.
      ST_WR: begin
        done_d[port_q] = 1'b1;
        state_d        = ST_DONE;
      end

      ST_DONE: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_100) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      port_q        <= PORT_ICACHE;
      last_served_q <= PORT_DCACHE;
      base_q        <= '0;
      word_q        <= '0;
      wait_q        <= '0;
      grant_q       <= '0;
      rvalid_q      <= '0;
      done_q        <= '0;
      rdata_q       <= '0;
      rword_q       <= '0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_we_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      port_q        <= port_d;
      last_served_q <= last_served_d;
      base_q        <= base_d;
      word_q        <= word_d;
      wait_q        <= wait_d;
      grant_q       <= grant_d;
      rvalid_q      <= rvalid_d;
      done_q        <= done_d;
      rdata_q       <= rdata_d;
      rword_q       <= rword_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_we_q      <= mem_we_d;
    end
  end

  assign req0_grant  = grant_q[0];
  assign req0_rvalid = rvalid_q[0];
  assign req0_done   = done_q[0];
  assign req0_rdata  = rdata_q[0];
  assign req0_rword  = rword_q[0];
  assign req1_grant  = grant_q[1];
  assign req1_rvalid = rvalid_q[1];
  assign req1_done   = done_q[1];
  assign req1_rdata  = rdata_q[1];
  assign req1_rword  = rword_q[1];
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_we      = mem_we_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed and random requests on a MEM_LAT=4
// instance checked every cycle against a transaction-timing model, plus a
// directed refill on a MEM_LAT=1 instance.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int unsigned LAT = 4;

  logic clk_100 = 1'b0;
  always #5 clk_100 = ~clk_100;

  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req0_we = 1'b0;
  logic [15:0] req0_addr = '0, req0_wdata = '0;
  logic        req1_valid = 1'b0, req1_we = 1'b0;
  logic [15:0] req1_addr = '0, req1_wdata = '0;
  logic        req0_grant, req0_rvalid, req0_done;
  logic        req1_grant, req1_rvalid, req1_done;
  logic [15:0] req0_rdata, req1_rdata;
  logic [1:0]  req0_rword, req1_rword;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  mem_port_arbiter #(.MEM_LAT(LAT)) u_dut (
    .clk_100(clk_100), .rst(rst),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_grant(req0_grant), .req0_rdata(req0_rdata), .req0_rvalid(req0_rvalid),
    .req0_rword(req0_rword), .req0_done(req0_done),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_grant(req1_grant), .req1_rdata(req1_rdata), .req1_rvalid(req1_rvalid),
    .req1_rword(req1_rword), .req1_done(req1_done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  // MEM_LAT=1 instance, port 1 idle.
  logic        f_valid = 1'b0;
  logic [15:0] f_addr = '0;
  logic        f_grant0, f_rvalid0, f_done0, f_grant1, f_rvalid1, f_done1, f_mem_we;
  logic [15:0] f_rdata0, f_rdata1, f_mem_addr, f_mem_wdata, f_mem_rdata;
  logic [1:0]  f_rword0, f_rword1;

  mem_port_arbiter #(.MEM_LAT(1)) u_dut_lat1 (
    .clk_100(clk_100), .rst(rst),
    .req0_valid(f_valid), .req0_we(1'b0), .req0_addr(f_addr), .req0_wdata(16'h0000),
    .req0_grant(f_grant0), .req0_rdata(f_rdata0), .req0_rvalid(f_rvalid0),
    .req0_rword(f_rword0), .req0_done(f_done0),
    .req1_valid(1'b0), .req1_we(1'b0), .req1_addr(16'h0000), .req1_wdata(16'h0000),
    .req1_grant(f_grant1), .req1_rdata(f_rdata1), .req1_rvalid(f_rvalid1),
    .req1_rword(f_rword1), .req1_done(f_done1),
    .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata), .mem_we(f_mem_we), .mem_rdata(f_mem_rdata)
  );

  assign f_mem_rdata = f_mem_addr ^ 16'hA5A5;

  // Memory model: data appears only once the address has been stable LAT cycles.
  logic [15:0] last_addr = '0;
  int          held = 0;
  int          cyc_held;
  always_comb cyc_held = (mem_addr == last_addr) ? held + 1 : 1;
  always_comb mem_rdata = (cyc_held >= int'(LAT)) ? (mem_addr ^ 16'hA5A5) : 16'hDEAD;
  always @(posedge clk_100) begin
    held      <= cyc_held;
    last_addr <= mem_addr;
  end

  int vec = 0;
  int errs = 0;
  int cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  // Transaction-level reference: one active transaction with start cycle t0.
  logic        m_act = 1'b0;
  int          m_t0 = 0;
  logic        m_port = 1'b0, m_we = 1'b0, m_last = 1'b1;
  logic [15:0] m_addr = '0, m_wdata = '0;
  logic [15:0] e_mem_addr = '0, e_mem_wdata = '0;
  logic [15:0] e_rdata [2] = '{16'h0, 16'h0};
  logic [1:0]  e_rword [2] = '{2'd0, 2'd0};

  always @(negedge clk_100) begin : model_blk
    int   d, k, len;
    logic [1:0] e_gnt, e_rv, e_done;
    logic e_we, idle_now, w;
    cyc++;
    e_gnt = '0; e_rv = '0; e_done = '0; e_we = 1'b0;
    d = 0; len = 0;
    idle_now = !m_act;
    if (m_act) begin
      d   = cyc - m_t0;
      len = m_we ? 2 : 4 * int'(LAT) + 1;
      if (d >= 1) e_gnt[m_port] = 1'b1;
      if (m_we) begin
        if (d == 1) begin
          e_we        = 1'b1;
          e_mem_addr  = m_addr;
          e_mem_wdata = m_wdata;
        end
      end else if (d >= 1) begin
        k = (d - 1) / int'(LAT);
        if (k > 3) k = 3;
        e_mem_addr = {m_addr[15:2], 2'(k)};
        if (d >= int'(LAT) + 1 && (d - 1) % int'(LAT) == 0) begin
          k = (d - 1) / int'(LAT) - 1;
          e_rv[m_port]    = 1'b1;
          e_rword[m_port] = 2'(k);
          e_rdata[m_port] = {m_addr[15:2], 2'(k)} ^ 16'hA5A5;
        end
      end
      if (d == len) e_done[m_port] = 1'b1;
    end

    check_eq("grant0",  32'(req0_grant),  32'(e_gnt[0]));
    check_eq("grant1",  32'(req1_grant),  32'(e_gnt[1]));
    check_eq("rvalid0", 32'(req0_rvalid), 32'(e_rv[0]));
    check_eq("rvalid1", 32'(req1_rvalid), 32'(e_rv[1]));
    check_eq("done0",   32'(req0_done),   32'(e_done[0]));
    check_eq("done1",   32'(req1_done),   32'(e_done[1]));
    check_eq("mem_we",  32'(mem_we),      32'(e_we));
    check_eq("mem_addr", 32'(mem_addr),   32'(e_mem_addr));
    check_eq("mem_wdata", 32'(mem_wdata), 32'(e_mem_wdata));
    check_eq("rdata0",  32'(req0_rdata),  32'(e_rdata[0]));
    check_eq("rdata1",  32'(req1_rdata),  32'(e_rdata[1]));
    check_eq("rword0",  32'(req0_rword),  32'(e_rword[0]));
    check_eq("rword1",  32'(req1_rword),  32'(e_rword[1]));

    if (m_act && d == len) m_act = 1'b0;

    if (rst) begin
      m_act = 1'b0; m_last = 1'b1;
      e_mem_addr = '0; e_mem_wdata = '0;
      e_rdata = '{16'h0, 16'h0};
      e_rword = '{2'd0, 2'd0};
    end else if (idle_now && (req0_valid || req1_valid)) begin
      w       = (req0_valid && req1_valid) ? !m_last : req1_valid;
      m_last  = w;
      m_act   = 1'b1;
      m_t0    = cyc;
      m_port  = w;
      m_we    = w ? req1_we    : req0_we;
      m_addr  = w ? req1_addr  : req0_addr;
      m_wdata = w ? req1_wdata : req0_wdata;
    end
  end

  // Requester side.
  logic [1:0] busy = '0;
  logic [1:0] gn_prev = '0;
  logic       auto_en = 1'b0;
  int         gnt_log[$];

  task automatic set_valid(input int p, input logic v);
    if (p == 0) req0_valid = v; else req1_valid = v;
  endtask

  task automatic issue(input int p, input logic we, input logic [15:0] a, input logic [15:0] wd);
    if (p == 0) begin
      req0_valid = 1'b1; req0_we = we; req0_addr = a; req0_wdata = wd;
    end else begin
      req1_valid = 1'b1; req1_we = we; req1_addr = a; req1_wdata = wd;
    end
    busy[p] = 1'b1;
  endtask

  // Advance one cycle; requesters drop valid on the edge ending their done cycle.
  task automatic step();
    logic [1:0] dn, gn;
    @(negedge clk_100);
    dn = {req1_done, req0_done};
    gn = {req1_grant, req0_grant};
    for (int p = 0; p < 2; p++) if (gn[p] && !gn_prev[p]) gnt_log.push_back(p);
    gn_prev = gn;
    @(posedge clk_100);
    #1;
    for (int p = 0; p < 2; p++) begin
      if (busy[p] && dn[p]) begin
        set_valid(p, 1'b0);
        busy[p] = 1'b0;
      end else if (auto_en && busy[p] && gn[p] && $urandom_range(0, 15) == 0) begin
        set_valid(p, 1'b0);
      end else if (auto_en && !busy[p] && $urandom_range(0, 2) == 0) begin
        issue(p, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
      end
    end
  endtask

  task automatic wait_free(input int limit);
    int n;
    n = 0;
    while (busy != 2'b00 && n < limit) begin
      step();
      n++;
    end
    check_eq("wait_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk_100);
    #1;
    rst = 1'b0;
    step();

    // Line refill on port 0, then a write-through on port 1.
    issue(0, 1'b0, 16'h12F7, 16'h0000);
    wait_free(100);
    issue(1, 1'b1, 16'h00C3, 16'hBEEF);
    wait_free(100);

    // Continuous contention: both ports keep a read pending.
    gnt_log.delete();
    issue(0, 1'b0, 16'h1000, 16'h0);
    issue(1, 1'b0, 16'h2000, 16'h0);
    for (int n = 0; n < 200 && gnt_log.size() < 4; n++) begin
      step();
      for (int p = 0; p < 2; p++)
        if (!busy[p]) issue(p, 1'b0, 16'($urandom), 16'h0);
    end
    check_eq("alt_count", 32'(gnt_log.size() >= 4), 32'd1);
    if (gnt_log.size() >= 4) begin
      check_eq("alt_order0", 32'(gnt_log[0]), 32'd0);
      check_eq("alt_order1", 32'(gnt_log[1]), 32'd1);
      check_eq("alt_order2", 32'(gnt_log[2]), 32'd0);
      check_eq("alt_order3", 32'(gnt_log[3]), 32'd1);
    end
    wait_free(200);

    // Write on port 1 arriving during word 1 of a port-0 refill.
    issue(0, 1'b0, 16'h3A41, 16'h0);
    repeat (LAT + 2) step();
    issue(1, 1'b1, 16'h5555, 16'h1234);
    wait_free(200);

    // Reset during word 2, then the same refill restarts from word 0.
    issue(0, 1'b0, 16'h7E01, 16'h0);
    repeat (2 * LAT + 2) step();
    rst = 1'b1;
    req0_valid = 1'b0;
    busy = '0;
    step();
    rst = 1'b0;
    step();
    issue(0, 1'b0, 16'h7E01, 16'h0);
    wait_free(100);

    // Random traffic.
    auto_en = 1'b1;
    repeat (1500) step();
    auto_en = 1'b0;
    wait_free(200);

    // MEM_LAT=1: four consecutive words, done with the last one.
    f_addr  = 16'h0042;
    f_valid = 1'b1;
    for (int d = 0; d <= 6; d++) begin
      @(negedge clk_100);
      check_eq("l1_rvalid", 32'(f_rvalid0), 32'(d >= 2 && d <= 5));
      check_eq("l1_done",   32'(f_done0),   32'(d == 5));
      check_eq("l1_grant",  32'(f_grant0),  32'(d >= 1 && d <= 5));
      check_eq("l1_port1",  32'({f_grant1, f_rvalid1, f_done1}), 32'd0);
      check_eq("l1_mem_we", 32'(f_mem_we), 32'd0);
      if (d >= 2 && d <= 5) begin
        check_eq("l1_rword", 32'(f_rword0), 32'(d - 2));
        check_eq("l1_rdata", 32'(f_rdata0), 32'((16'h0040 + 16'(d - 2)) ^ 16'hA5A5));
      end
      @(posedge clk_100);
      #1;
      if (d == 5) f_valid = 1'b0;
    end
    check_eq("l1_port1_data", 32'({f_rdata1, f_mem_wdata}), 32'd0);
    check_eq("l1_port1_rword", 32'(f_rword1), 32'd0);

    @(negedge clk_100);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
